// File: rtl/stack_unit_if.sv
// +----------------------------------------------------------------------------
// | stack_unit_if : control <-> operand stack strobe/data bundle.
// | Optional STACK_NOS_EN adds the next-on-stack output nos.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

interface stack_unit_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic               push;
    logic               pop;
    logic               stack_src;
    logic [DATA_W-1:0]  alu_result;
    logic [DATA_W-1:0]  mdr_data;
    logic               clear_err;
    logic [DATA_W-1:0]  tos;
    logic               tos_zero;
    logic [c_CNT_W-1:0] count;
    logic               empty;
    logic               full;
    logic               overflow;
    logic               underflow;
`ifdef STACK_NOS_EN
    logic [DATA_W-1:0]  nos;
`endif

    modport master (
        output push, pop, stack_src, alu_result, mdr_data, clear_err,
`ifdef STACK_NOS_EN
        input  nos,
`endif
        input  tos, tos_zero, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, stack_src, alu_result, mdr_data, clear_err,
`ifdef STACK_NOS_EN
        output nos,
`endif
        output tos, tos_zero, count, empty, full, overflow, underflow
    );
endinterface

`default_nettype wire

// File: rtl/stack_unit.sv
// +----------------------------------------------------------------------------
// | stack_unit : operand stack with a cached top-of-stack register.
// | Optional STACK_NOS_EN: cached next-on-stack register driving bus.nos.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module stack_unit #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic         clk,
    input  logic         reset,
    stack_unit_if.slave  bus
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam int c_SP_W  = $clog2(DEPTH);

    logic [DATA_W-1:0]  r_tos;
    logic [DATA_W-1:0]  r_body [0:DEPTH-2];
    logic [c_SP_W-1:0]  r_sp;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic               r_underflow;
`ifdef STACK_NOS_EN
    logic [DATA_W-1:0]  r_nos;
`endif

    logic [DATA_W-1:0]  w_din;
    logic               w_empty;
    logic               w_full;
    logic               w_do_push;
    logic               w_do_pop;
    logic               w_replace;
    logic               w_set_ovf;
    logic               w_set_unf;
    logic [c_SP_W-1:0]  w_sp_m1;
`ifdef STACK_NOS_EN
    logic [c_SP_W-1:0]  w_sp_m2;
`endif

    assign w_din     = bus.stack_src ? bus.mdr_data : bus.alu_result;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_CNT_W'(DEPTH));
    // A replace on an empty stack has nothing to pop, so it degrades to a push.
    assign w_do_push = (bus.push & ~bus.pop & ~w_full) | (bus.push & bus.pop & w_empty);
    assign w_do_pop  = bus.pop & ~bus.push & ~w_empty;
    assign w_replace = bus.push & bus.pop & ~w_empty;
    assign w_set_ovf = bus.push & ~bus.pop & w_full;
    assign w_set_unf = bus.pop & ~bus.push & w_empty;
    assign w_sp_m1   = r_sp - c_SP_W'(1);
`ifdef STACK_NOS_EN
    assign w_sp_m2   = r_sp - c_SP_W'(2);
`endif

    // Body is not reset; its contents are only read below a valid count.
    always_ff @(posedge clk) begin
        if (w_do_push && !w_empty) begin
            r_body[r_sp] <= r_tos;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tos       <= '0;
            r_sp        <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
`ifdef STACK_NOS_EN
            r_nos       <= '0;
`endif
        end else begin
            if (w_do_push) begin
                r_tos   <= w_din;
                r_count <= r_count + c_CNT_W'(1);
                if (!w_empty) begin
                    r_sp <= r_sp + c_SP_W'(1);
                end
`ifdef STACK_NOS_EN
                r_nos <= w_empty ? '0 : r_tos;
`endif
            end else if (w_do_pop) begin
                r_count <= r_count - c_CNT_W'(1);
                if (r_count == c_CNT_W'(1)) begin
                    r_tos <= '0;
                end else begin
                    r_tos <= r_body[w_sp_m1];
                    r_sp  <= w_sp_m1;
                end
`ifdef STACK_NOS_EN
                r_nos <= (r_count > c_CNT_W'(2)) ? r_body[w_sp_m2] : '0;
`endif
            end else if (w_replace) begin
                r_tos <= w_din;
            end

            // A set in the same cycle as clear_err wins.
            r_overflow  <= (r_overflow  & ~bus.clear_err) | w_set_ovf;
            r_underflow <= (r_underflow & ~bus.clear_err) | w_set_unf;
        end
    end

    assign bus.tos       = r_tos;
    assign bus.tos_zero  = (r_tos == '0);
    assign bus.count     = r_count;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`ifdef STACK_NOS_EN
    assign bus.nos       = r_nos;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stack_unit.sv
// +----------------------------------------------------------------------------
// | tb_stack_unit : directed and randomized checks of stack_unit (DEPTH=4).
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_stack_unit;
    localparam int DW = 8;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    stack_unit_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

    stack_unit #(.DATA_W(DW), .DEPTH(DP)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a plain queue, back = top of stack.
    logic [7:0] stk[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    function automatic logic [7:0] m_tos();
        if (stk.size() == 0) return 8'h00;
        return stk[stk.size()-1];
    endfunction

    function automatic logic [7:0] m_nos();
        if (stk.size() < 2) return 8'h00;
        return stk[stk.size()-2];
    endfunction

    task automatic apply(input logic p, input logic q, input logic src,
                         input logic [7:0] alu, input logic [7:0] mdr, input logic clr);
        logic [7:0] din;
        logic so;
        logic su;
        so = 1'b0;
        su = 1'b0;
        bus.push = p; bus.pop = q; bus.stack_src = src;
        bus.alu_result = alu; bus.mdr_data = mdr; bus.clear_err = clr;
        @(posedge clk);
        #1;
        din = src ? mdr : alu;
        case ({p, q})
            2'b10: if (stk.size() == DP) so = 1'b1; else stk.push_back(din);
            2'b01: if (stk.size() == 0) su = 1'b1; else void'(stk.pop_back());
            2'b11: if (stk.size() == 0) stk.push_back(din); else stk[stk.size()-1] = din;
            default: ;
        endcase
        m_ovf = (m_ovf & ~clr) | so;
        m_unf = (m_unf & ~clr) | su;
        bus.push = 1'b0; bus.pop = 1'b0; bus.clear_err = 1'b0;
    endtask

    task automatic drain();
        while (stk.size() > 0) apply(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        #1;
        n_vec++; if (bus.tos !== 8'h00) begin n_err++; $display("FAIL reset tos: got %h want 00", bus.tos); end
        n_vec++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL reset count: got %0d want 0", bus.count); end
        n_vec++; if (bus.empty !== 1'b1 || bus.tos_zero !== 1'b1 || bus.full !== 1'b0) begin
            n_err++; $display("FAIL reset flags: empty=%b tos_zero=%b full=%b want 1 1 0", bus.empty, bus.tos_zero, bus.full); end
        n_vec++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            n_err++; $display("FAIL reset err: ovf=%b unf=%b want 0 0", bus.overflow, bus.underflow); end
        @(posedge clk); #1; reset = 1'b1;
        apply(1'b1, 1'b0, 1'b0, 8'h21, 8'h00, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 8'h43, 8'h00, 1'b0);
        // Async reset in the middle of a push cycle
        bus.push = 1'b1; bus.stack_src = 1'b0; bus.alu_result = 8'h5A;
        @(posedge clk); #2; reset = 1'b0; #1;
        stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        n_vec++; if (bus.tos !== 8'h00 || bus.count !== 3'd0) begin
            n_err++; $display("FAIL midreset tos/count: got %h/%0d want 00/0", bus.tos, bus.count); end
        n_vec++; if (bus.empty !== 1'b1 || bus.tos_zero !== 1'b1) begin
            n_err++; $display("FAIL midreset flags: empty=%b tos_zero=%b want 1 1", bus.empty, bus.tos_zero); end
        @(posedge clk); #1;
        n_vec++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL held_reset count: got %0d want 0", bus.count); end
        reset = 1'b1;
        apply(1'b1, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b0);
        n_vec++; if (bus.tos !== 8'h5A || bus.count !== 3'd1) begin
            n_err++; $display("FAIL post_reset push: got %h/%0d want 5a/1", bus.tos, bus.count); end
    endtask

    task automatic test_push_pop();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'h22; exp_seq[1] = 8'h11; exp_seq[2] = 8'h00;
        drain();
        apply(1'b1, 1'b0, 1'b0, 8'h11, 8'hEE, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 8'h22, 8'hEE, 1'b0);
        apply(1'b1, 1'b0, 1'b1, 8'hEE, 8'h33, 1'b0);
        n_vec++; if (bus.tos !== 8'h33 || bus.count !== 3'd3) begin
            n_err++; $display("FAIL push3: got %h/%0d want 33/3", bus.tos, bus.count); end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
            n_vec++; if (bus.tos !== exp_seq[i]) begin
                n_err++; $display("FAIL pop%0d tos: got %h want %h", i, bus.tos, exp_seq[i]); end
        end
        n_vec++; if (bus.empty !== 1'b1 || bus.tos_zero !== 1'b1 || bus.count !== 3'd0) begin
            n_err++; $display("FAIL popped_empty: empty=%b tos_zero=%b count=%0d want 1 1 0", bus.empty, bus.tos_zero, bus.count); end
    endtask

    task automatic test_overflow();
        drain();
        for (int i = 0; i < DP; i++) apply(1'b1, 1'b0, 1'b0, 8'(8'h40 + i), 8'h00, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 8'h99, 8'h00, 1'b0);
        n_vec++; if (bus.tos !== 8'h43 || bus.count !== 3'd4) begin
            n_err++; $display("FAIL ovf push: got %h/%0d want 43/4", bus.tos, bus.count); end
        n_vec++; if (bus.full !== 1'b1 || bus.overflow !== 1'b1) begin
            n_err++; $display("FAIL ovf flags: full=%b ovf=%b want 1 1", bus.full, bus.overflow); end
        apply(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf clear: got %b want 0", bus.overflow); end
    endtask

    task automatic test_underflow();
        drain();
        apply(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        n_vec++; if (bus.count !== 3'd0 || bus.underflow !== 1'b1 || bus.tos !== 8'h00) begin
            n_err++; $display("FAIL unf pop: count=%0d unf=%b tos=%h want 0 1 00", bus.count, bus.underflow, bus.tos); end
        apply(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
        n_vec++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL unf set_wins: got %b want 1", bus.underflow); end
        apply(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        n_vec++; if (bus.underflow !== 1'b0) begin n_err++; $display("FAIL unf clear: got %b want 0", bus.underflow); end
    endtask

    task automatic test_replace();
        drain();
        apply(1'b1, 1'b0, 1'b0, 8'h03, 8'h00, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 8'h07, 8'h00, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0);
        n_vec++; if (bus.tos !== 8'h00 || bus.tos_zero !== 1'b1 || bus.count !== 3'd2) begin
            n_err++; $display("FAIL replace: tos=%h tos_zero=%b count=%0d want 00 1 2", bus.tos, bus.tos_zero, bus.count); end
        n_vec++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            n_err++; $display("FAIL replace err: ovf=%b unf=%b want 0 0", bus.overflow, bus.underflow); end
        apply(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        n_vec++; if (bus.tos !== 8'h03) begin n_err++; $display("FAIL replace pop: got %h want 03", bus.tos); end
        drain();
        apply(1'b1, 1'b1, 1'b1, 8'h00, 8'h6C, 1'b0);
        n_vec++; if (bus.tos !== 8'h6C || bus.count !== 3'd1 || bus.underflow !== 1'b0) begin
            n_err++; $display("FAIL replace_empty: tos=%h count=%0d unf=%b want 6c 1 0", bus.tos, bus.count, bus.underflow); end
    endtask

`ifdef STACK_NOS_EN
    task automatic test_nos();
        drain();
        apply(1'b1, 1'b0, 1'b0, 8'hA1, 8'h00, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 8'hB2, 8'h00, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 8'hC3, 8'h00, 1'b0);
        n_vec++; if (bus.tos !== 8'hC3 || bus.nos !== 8'hB2) begin
            n_err++; $display("FAIL nos push: tos=%h nos=%h want c3 b2", bus.tos, bus.nos); end
        apply(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        n_vec++; if (bus.tos !== 8'hB2 || bus.nos !== 8'hA1) begin
            n_err++; $display("FAIL nos pop1: tos=%h nos=%h want b2 a1", bus.tos, bus.nos); end
        apply(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        n_vec++; if (bus.nos !== 8'h00) begin n_err++; $display("FAIL nos pop2: got %h want 00", bus.nos); end
    endtask
`endif

    task automatic test_random();
        int sel;
        logic p, q, clr;
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 9));
            p   = (sel <= 3) || (sel == 7);
            q   = (sel >= 4 && sel <= 7);
            clr = ($urandom_range(0, 15) == 0);
            apply(p, q, 1'($urandom), 8'($urandom), 8'($urandom), clr);
            n_vec++; if (bus.tos !== m_tos()) begin
                n_err++; $display("FAIL rand[%0d] tos: got %h want %h", i, bus.tos, m_tos()); end
            n_vec++; if (bus.count !== 3'(stk.size())) begin
                n_err++; $display("FAIL rand[%0d] count: got %0d want %0d", i, bus.count, stk.size()); end
            n_vec++; if (bus.tos_zero !== (m_tos() == 8'h00)) begin
                n_err++; $display("FAIL rand[%0d] tos_zero: got %b want %b", i, bus.tos_zero, m_tos() == 8'h00); end
            n_vec++; if (bus.empty !== (stk.size() == 0) || bus.full !== (stk.size() == DP)) begin
                n_err++; $display("FAIL rand[%0d] empty/full: got %b/%b want %b/%b", i, bus.empty, bus.full, stk.size() == 0, stk.size() == DP); end
            n_vec++; if (bus.overflow !== m_ovf || bus.underflow !== m_unf) begin
                n_err++; $display("FAIL rand[%0d] err: got %b/%b want %b/%b", i, bus.overflow, bus.underflow, m_ovf, m_unf); end
`ifdef STACK_NOS_EN
            n_vec++; if (bus.nos !== m_nos()) begin
                n_err++; $display("FAIL rand[%0d] nos: got %h want %h", i, bus.nos, m_nos()); end
`endif
        end
    endtask

    initial begin
        bus.push = 1'b0; bus.pop = 1'b0; bus.stack_src = 1'b0;
        bus.alu_result = 8'h00; bus.mdr_data = 8'h00; bus.clear_err = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_replace();
`ifdef STACK_NOS_EN
        test_nos();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Operand stack for the multicycle stack CPU; the responder to the control FSM's push/pop/stack_src strobes.
- Supplies the top-of-stack to the A/B operand latches and the memory write path.
- Supplies tos_zero back to the control FSM for JZ.
- Top-of-stack is held in a dedicated register, so TOS is valid in the same cycle the control FSM pops it.

Parameters:
- DATA_W, 8, width of stack entries, ALU result and MDR.
- DEPTH, 16, maximum number of entries, TOS register included; must be a power of two and at least 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- push  input  1  push strobe from control, one cycle per push
- pop  input  1  pop strobe from control, one cycle per pop
- stack_src  input  1  push data select: 0 = alu_result, 1 = mdr_data
- alu_result  input  DATA_W  ALU output
- mdr_data  input  DATA_W  memory data register output
- tos  output  DATA_W  current top-of-stack; 0 when empty
- tos_zero  output  1  tos == 0 (also 1 when empty)
- count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- overflow  output  1  sticky: push attempted while full
- underflow  output  1  sticky: pop attempted while empty
- clear_err  input  1  synchronous clear of overflow and underflow

Behaviour:
- Storage:
  - tos_reg holds the top entry.
  - Array body[0..DEPTH-2] holds the lower entries.
  - sp indexes the next free body slot; sp = count-1 when count > 0.
- din = stack_src ? mdr_data : alu_result, selected combinationally.
- Reset (reset low, async):
  - tos_reg=0, count=0, sp=0, overflow=0, underflow=0.
  - Resulting outputs: tos=0, tos_zero=1, empty=1, full=0.
  - Body contents are don't-care.
  - Takes effect mid-operation, with no completion of an in-flight strobe.
- All updates happen on the rising clk edge. Outputs are registered or derived from registers; no combinational path from push/pop to tos.
- Operation select per edge, on {push,pop}:
  - 00: hold.
  - 10 push, not full:
    - If count > 0: body[sp] <= tos_reg and sp <= sp+1.
    - tos_reg <= din; count+1.
  - 10 push, full: state unchanged; overflow <= 1.
  - 01 pop, count > 1: tos_reg <= body[sp-1]; sp-1; count-1.
  - 01 pop, count == 1: tos_reg <= 0; count <= 0; sp stays 0.
  - 01 pop, empty: state unchanged; underflow <= 1.
  - 11 replace, not empty: tos_reg <= din; count unchanged. This is the same-cycle pop-then-push result.
  - 11 replace, empty: treated as a plain push (count becomes 1); underflow not set.
- Error flags:
  - clear_err clears overflow/underflow.
  - A set event in the same cycle as clear_err wins (flag ends at 1).
- Popped value: the consumer samples tos in the cycle pop is high. After the edge, tos shows the new top.
- Latency: push/pop effect visible on tos/count one cycle after the strobe edge.
- count width: $clog2(DEPTH)+1 so that DEPTH is representable. Arithmetic never wraps; guarded by the full/empty checks.

Optional Feature:
- Macro: STACK_NOS_EN
- Defined:
  - Adds output port nos (DATA_W), the next-on-stack value.
  - nos = body[sp-1] when count >= 2, else 0.
  - nos is driven from a second cached register nos_reg, updated with the same push/pop rules (push: nos_reg <= tos_reg; pop: nos_reg <= body[sp-2] or 0), so it is register-driven.
  - Body capacity is unchanged.
- Undefined: no nos port; no nos_reg; behaviour otherwise identical.

Test Plan:
1. Reset low mid-push (push=1, stack_src=0, alu_result=8'h5A) → tos=0, count=0, empty=1, tos_zero=1. After release and one push cycle, tos=8'h5A, count=1.
2. DEPTH=4: push 8'h11, 8'h22 (alu, stack_src=0), then 8'h33 (mdr, stack_src=1) → tos=8'h33, count=3. Then pop ×3 → tos 8'h22, 8'h11, 0; empty=1; tos_zero=1.
3. DEPTH=4 full (count=4), push 8'h99 → tos unchanged, count=4, full=1, overflow=1. Then clear_err → overflow=0.
4. Empty stack, pop → count=0, underflow=1, tos=0. Pop and clear_err in the same cycle → underflow stays 1.
5. tos=8'h07, count=2, push=pop=1, alu_result=8'h00 → tos=8'h00, tos_zero=1, count=2, no error flags set.
6. With STACK_NOS_EN defined: push 8'hA1, 8'hB2, 8'hC3 → tos=8'hC3, nos=8'hB2. Pop → tos=8'hB2, nos=8'hA1. Pop → nos=0.
